// File: rtl/tnoc_packet_packer.sv
// Packs one NoC packet (header flits, then payload beats) into a head/tail-marked flit stream.
// Optional TNOC_PACKER_OUTPUT_REG_EN adds a 2-entry skid buffer on the flit output.
module tnoc_packet_packer #(
   parameter int FLIT_DATA_WIDTH       = 64,
   parameter int REQUEST_HEADER_FLITS  = 2,
   parameter int RESPONSE_HEADER_FLITS = 1,
   localparam int HEADER_FLITS = (REQUEST_HEADER_FLITS > RESPONSE_HEADER_FLITS) ?
                                 REQUEST_HEADER_FLITS : RESPONSE_HEADER_FLITS
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    header_valid,
   output logic                                    header_ready,
   input  logic                                    header_is_request,
   input  logic                                    header_has_payload,
   input  logic [HEADER_FLITS*FLIT_DATA_WIDTH-1:0] header_data,
   input  logic                                    payload_valid,
   output logic                                    payload_ready,
   input  logic [FLIT_DATA_WIDTH-1:0]              payload_data,
   input  logic                                    payload_last,
   output logic                                    flit_valid,
   input  logic                                    flit_ready,
   output logic                                    flit_head,
   output logic                                    flit_tail,
   output logic [FLIT_DATA_WIDTH-1:0]              flit_data
);

   localparam int W = FLIT_DATA_WIDTH;
   localparam logic [1:0] REQ_LAST = 2'(REQUEST_HEADER_FLITS - 1);
   localparam logic [1:0] RSP_LAST = 2'(RESPONSE_HEADER_FLITS - 1);

   typedef enum logic {HEADER = 1'b0, PAYLOAD = 1'b1} state_t;

   state_t       state_reg, state_next;
   logic [1:0]   count_reg, count_next;
   logic [W-1:0] header_slice [4];
   logic         last_header;
   logic         core_ready;
   logic         fsm_valid, fsm_head, fsm_tail;
   logic [W-1:0] fsm_data;
   logic         fsm_header_ready, fsm_payload_ready;
   logic         out_valid, out_head, out_tail;
   logic [W-1:0] out_data;

   // Slots beyond HEADER_FLITS read as zero so the 2-bit count can index safely.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_slice
         if (gi < HEADER_FLITS) begin : g_used
            assign header_slice[gi] = header_data[gi*W +: W];
         end else begin : g_unused
            assign header_slice[gi] = '0;
         end
      end
   endgenerate

   assign last_header = (count_reg == (header_is_request ? REQ_LAST : RSP_LAST));

   always_comb begin
      state_next        = state_reg;
      count_next        = count_reg;
      fsm_valid         = 1'b0;
      fsm_head          = 1'b1;
      fsm_tail          = 1'b0;
      fsm_data          = '0;
      fsm_header_ready  = 1'b0;
      fsm_payload_ready = 1'b0;
      case (state_reg)
         HEADER: begin
            fsm_valid = header_valid;
            fsm_data  = header_valid ? header_slice[count_reg] : '0;
            fsm_tail  = header_valid && last_header && !header_has_payload;
            if (last_header) fsm_header_ready = core_ready;
            if (header_valid && core_ready) begin
               if (last_header) begin
                  count_next = '0;
                  state_next = header_has_payload ? PAYLOAD : HEADER;
               end else begin
                  count_next = count_reg + 2'd1;
               end
            end
         end
         PAYLOAD: begin
            fsm_head          = 1'b0;
            fsm_valid         = payload_valid;
            fsm_data          = payload_valid ? payload_data : '0;
            fsm_tail          = payload_valid && payload_last;
            fsm_payload_ready = core_ready;
            if (payload_valid && core_ready && payload_last) state_next = HEADER;
         end
         default: state_next = HEADER;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= HEADER;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
      end
   end

`ifdef TNOC_PACKER_OUTPUT_REG_EN
   logic [W+1:0] buf_mem [2];
   logic [1:0]   buf_cnt_reg;
   logic         buf_wr_reg, buf_rd_reg;
   logic         buf_push, buf_pop, buf_valid;
   logic [W+1:0] buf_out;

   // Accepting only while not full keeps flit_ready out of the upstream ready paths.
   assign core_ready = !buf_cnt_reg[1];
   assign buf_valid  = (buf_cnt_reg != 2'd0);
   assign buf_push   = fsm_valid && core_ready;
   assign buf_pop    = buf_valid && flit_ready;
   assign buf_out    = buf_mem[buf_rd_reg];

   always_ff @(posedge clk) begin
      if (buf_push) buf_mem[buf_wr_reg] <= {fsm_head, fsm_tail, fsm_data};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         buf_cnt_reg <= '0;
         buf_wr_reg  <= 1'b0;
         buf_rd_reg  <= 1'b0;
      end else begin
         if (buf_push) buf_wr_reg <= ~buf_wr_reg;
         if (buf_pop)  buf_rd_reg <= ~buf_rd_reg;
         buf_cnt_reg <= buf_cnt_reg + 2'(buf_push) - 2'(buf_pop);
      end
   end

   assign out_valid = buf_valid;
   assign out_head  = buf_valid ? buf_out[W+1] : 1'b1;
   assign out_tail  = buf_valid && buf_out[W];
   assign out_data  = buf_valid ? buf_out[W-1:0] : '0;
`else
   assign core_ready = flit_ready;
   assign out_valid  = fsm_valid;
   assign out_head   = fsm_head;
   assign out_tail   = fsm_tail;
   assign out_data   = fsm_data;
`endif

   // Outputs show their idle values for the whole reset cycle.
   assign header_ready  = rst_n && fsm_header_ready;
   assign payload_ready = rst_n && fsm_payload_ready;
   assign flit_valid    = rst_n && out_valid;
   assign flit_head     = !rst_n || out_head;
   assign flit_tail     = rst_n && out_tail;
   assign flit_data     = rst_n ? out_data : '0;

endmodule

// File: tb/tb_tnoc_packet_packer.sv
// Self-checking bench for tnoc_packet_packer: scoreboard of expected flits, directed and random traffic.
module tb_tnoc_packet_packer;

   localparam int W = 64;
`ifdef TNOC_PACKER_OUTPUT_REG_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   typedef struct packed {
      logic         head;
      logic         tail;
      logic [W-1:0] data;
   } flit_t;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           header_valid = 1'b0;
   logic           header_ready;
   logic           header_is_request = 1'b0;
   logic           header_has_payload = 1'b0;
   logic [2*W-1:0] header_data = '0;
   logic           payload_valid = 1'b0;
   logic           payload_ready;
   logic [W-1:0]   payload_data = '0;
   logic           payload_last = 1'b0;
   logic           flit_valid;
   logic           flit_ready = 1'b0;
   logic           flit_head;
   logic           flit_tail;
   logic [W-1:0]   flit_data;

   flit_t        sb_q[$];
   flit_t        mon_e;
   logic [W-1:0] pl_buf [8];
   int           checks = 0;
   int           failures = 0;
   int           rnd_ready = 0;
   int           cyc = 0;
   int           n_flits = 0;
   int           last_flit_cyc = 0;
   int           prev_flit_cyc = 0;

   always #5 clk = ~clk;

   tnoc_packet_packer dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .header_valid       (header_valid),
      .header_ready       (header_ready),
      .header_is_request  (header_is_request),
      .header_has_payload (header_has_payload),
      .header_data        (header_data),
      .payload_valid      (payload_valid),
      .payload_ready      (payload_ready),
      .payload_data       (payload_data),
      .payload_last       (payload_last),
      .flit_valid         (flit_valid),
      .flit_ready         (flit_ready),
      .flit_head          (flit_head),
      .flit_tail          (flit_tail),
      .flit_data          (flit_data)
   );

   task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_ready != 0) flit_ready = 1'($urandom_range(0, 1));
      end
   end

   // Every accepted flit is matched against the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && flit_valid && flit_ready) begin
         if (sb_q.size() == 0) begin
            check_val("unexpected_flit", 1, 0);
         end else begin
            mon_e = sb_q.pop_front();
            check_val("flit_head", flit_head, mon_e.head);
            check_val("flit_tail", flit_tail, mon_e.tail);
            check_val("flit_data", flit_data, mon_e.data);
            n_flits++;
            prev_flit_cyc = last_flit_cyc;
            last_flit_cyc = cyc;
            $display("flit %0d cyc=%0d head=%0b tail=%0b data=%h", n_flits, cyc, flit_head, flit_tail, flit_data);
         end
      end
   end

   task automatic drive_header(input int n, input bit chk_timing, input bit chk_lat);
      int  waits = 0;
      bit  done = 0;
      header_valid = 1'b1;
      for (int i = 0; i < 1000 && !done; i++) begin
         @(negedge clk);
         if (chk_lat && i == 0) check_val("first_flit_valid", flit_valid, (LAT == 0) ? 1 : 0);
         if (header_ready) done = 1;
         else waits++;
      end
      if (!done) check_val("header_timeout", 0, 1);
      if (chk_timing) check_val("header_ready_cycle", waits, n - 1);
      @(posedge clk);
      #1;
      header_valid = 1'b0;
   endtask

   task automatic drive_payload(input int nb);
      bit done;
      for (int b = 0; b < nb; b++) begin
         payload_valid = 1'b1;
         payload_data  = pl_buf[b];
         payload_last  = (b == nb - 1);
         done = 0;
         for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            if (b == 0 && i == 0) check_val("payload_ready_in_header", payload_ready, 0);
            if (payload_ready) done = 1;
         end
         if (!done) check_val("payload_timeout", 0, 1);
         @(posedge clk);
         #1;
      end
      payload_valid = 1'b0;
      payload_last  = 1'b0;
   endtask

   task automatic send_packet(input bit is_req, input bit has_pl, input int nb,
                              input logic [2*W-1:0] hd, input bit chk_timing, input bit chk_lat);
      flit_t f;
      int    n;
      n = is_req ? 2 : 1;
      for (int i = 0; i < n; i++) begin
         f.head = 1'b1;
         f.tail = (i == n - 1) && !has_pl;
         f.data = hd[i*W +: W];
         sb_q.push_back(f);
      end
      for (int b = 0; b < nb; b++) begin
         pl_buf[b] = {$urandom, $urandom};
         f.head = 1'b0;
         f.tail = (b == nb - 1);
         f.data = pl_buf[b];
         sb_q.push_back(f);
      end
      header_is_request  = is_req;
      header_has_payload = has_pl;
      header_data        = hd;
      fork
         drive_header(n, chk_timing, chk_lat);
         drive_payload(nb);
      join
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 2000 && sb_q.size() != 0; i++) @(negedge clk);
      check_val(tag, sb_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_flit_valid"}, flit_valid, 0);
      check_val({tag, "_header_ready"}, header_ready, 0);
      check_val({tag, "_payload_ready"}, payload_ready, 0);
      check_val({tag, "_flit_head"}, flit_head, 1);
      check_val({tag, "_flit_tail"}, flit_tail, 0);
      check_val({tag, "_flit_data"}, flit_data, 0);
   endtask

   initial begin
      flit_t f;
      bit    hr_seen;
      bit    done;
      logic [2*W-1:0] hd;

      // Reset with live-looking inputs: outputs must still be idle.
      header_valid  = 1'b1;
      header_data   = {64'h1111, 64'h2222};
      payload_valid = 1'b1;
      flit_ready    = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #1;
      header_valid  = 1'b0;
      payload_valid = 1'b0;
      rst_n         = 1'b1;
      @(posedge clk);
      #1;

      $display("test: request header, no payload");
      send_packet(1'b1, 1'b0, 0, {64'hB, 64'hA}, 1'b1, 1'b1);
      drain("drain_t1");

      $display("test: response with three payload beats");
      send_packet(1'b0, 1'b1, 3, {64'hDEAD_0000_0000_0001, 64'h0000_0000_0000_00C0}, 1'b1, 1'b0);
      drain("drain_t2");

      $display("test: stall mid-header");
      f.head = 1'b1; f.tail = 1'b0; f.data = 64'hC;
      sb_q.push_back(f);
      f.tail = 1'b1; f.data = 64'hD;
      sb_q.push_back(f);
      header_is_request  = 1'b1;
      header_has_payload = 1'b0;
      header_data        = {64'hD, 64'hC};
      header_valid       = 1'b1;
      flit_ready         = 1'b1;
      @(posedge clk);
      #1;
      flit_ready = 1'b0;
      hr_seen    = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_val("stall_valid", flit_valid, 1);
         check_val("stall_data", flit_data, (LAT == 0) ? 64'hD : 64'hC);
         if (LAT == 0) check_val("stall_header_ready", header_ready, 0);
         if (header_ready) hr_seen = 1;
         @(posedge clk);
         #1;
         if (hr_seen) header_valid = 1'b0;
      end
      flit_ready = 1'b1;
      if (!hr_seen) begin
         done = 0;
         for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (header_ready) done = 1;
         end
         check_val("stall_release", done, 1);
         @(posedge clk);
         #1;
         header_valid = 1'b0;
      end
      drain("drain_t3");

      $display("test: reset after first payload beat");
      f.head = 1'b1; f.tail = 1'b0; f.data = 64'h4848;
      sb_q.push_back(f);
      f.head = 1'b0; f.data = 64'hD0D0;
      sb_q.push_back(f);
      header_is_request  = 1'b0;
      header_has_payload = 1'b1;
      header_data        = {64'h9999, 64'h4848};
      header_valid       = 1'b1;
      payload_valid      = 1'b1;
      payload_data       = 64'hD0D0;
      payload_last       = 1'b0;
      @(negedge clk);
      check_val("rst_hdr_accept", header_ready, 1);
      check_val("rst_pl_blocked", payload_ready, 0);
      @(posedge clk);
      #1;
      header_valid = 1'b0;
      @(negedge clk);
      check_val("rst_beat_accept", payload_ready, 1);
      @(posedge clk);
      #1;
      rst_n        = 1'b0;
      payload_data = 64'hD1D1;
      if (LAT == 0) check_val("sb_before_reset", sb_q.size(), 0);
      sb_q.delete();
      @(negedge clk);
      check_reset_outputs("midreset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_val("post_rst_payload_ready", payload_ready, 0);
      check_val("post_rst_flit_valid", flit_valid, 0);
      @(posedge clk);
      #1;
      payload_valid = 1'b0;
      send_packet(1'b1, 1'b0, 0, {64'hF, 64'hE}, 1'b1, 1'b0);
      drain("drain_t4");

      $display("test: back-to-back single-flit responses");
      send_packet(1'b0, 1'b0, 0, {64'h0, 64'h51}, 1'b1, 1'b0);
      send_packet(1'b0, 1'b0, 0, {64'h0, 64'h52}, 1'b1, 1'b0);
      drain("drain_t5");
      check_val("b2b_gap", last_flit_cyc - prev_flit_cyc, 1);

      $display("test: random packets with random flit_ready");
      rnd_ready = 1;
      for (int p = 0; p < 24; p++) begin
         bit is_req, has_pl;
         int nb;
         is_req = 1'($urandom_range(0, 1));
         has_pl = 1'($urandom_range(0, 1));
         nb     = has_pl ? int'($urandom_range(1, 4)) : 0;
         hd     = {$urandom, $urandom, $urandom, $urandom};
         send_packet(is_req, has_pl, nb, hd, 1'b0, 1'b0);
      end
      rnd_ready  = 0;
      flit_ready = 1'b1;
      drain("drain_random");
      check_val("flit_count_nonzero", (n_flits > 30) ? 1 : 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
